// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Owns the fetch PC, drives the instruction memory address and assembles
// one- and two-word instructions into the IF/ID pipeline register.
// A word whose top two bits are 2'b11 starts a two-word instruction; the
// word after it is that instruction's immediate.
//
// Handshake with Decode:
//   The IF/ID register presents a new instruction in each cycle where
//   if_valid=1. Decode holds the register by raising stall. While stall is
//   high (and redirect_en is low), every piece of fetch state and every
//   IF/ID output keeps its value. redirect_en outranks stall. It reloads
//   the PC and places a bubble (if_valid=0) into IF/ID at the same edge.
//   No IF/ID output depends combinationally on stall or redirect_en. Only
//   imem_addr is combinational, and it always equals pc.

module fetch_unit #(
    parameter int unsigned        ADDR_W   = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [15:0]        NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       if_instr,
    output logic [15:0]       if_imm,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              dbg_state_o
);

    // S_OP fetches an instruction word. S_IMM fetches the immediate of a
    // two-word instruction whose first word waits in the hold register.
    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       hold_q, hold_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [15:0]       if_instr_q, if_instr_d;
    logic [15:0]       if_imm_q, if_imm_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              if_valid_q, if_valid_d;

    logic              is_two_word;
    logic [ADDR_W-1:0] pc_inc;

    // The opcode class is decoded only in S_OP.
    assign is_two_word = (imem_data[15:14] == 2'b11);
    // Natural wrap modulo 2^ADDR_W. A two-word instruction at the last
    // address takes its immediate from address 0.
    assign pc_inc      = pc_q + PC_ONE;

    // State register. Reset wins over everything, including a mid-instruction S_IMM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Redirect beats stall, and stall beats normal sequencing.
    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = S_OP;
        end else if (!stall) begin
            case (state_q)
                S_OP:    state_d = is_two_word ? S_IMM : S_OP;
                S_IMM:   state_d = S_OP;
                default: state_d = S_OP;
            endcase
        end
    end

    // Output logic: the next values of the PC, the hold register and IF/ID.
    always_comb begin
        pc_d       = pc_q;
        hold_d     = hold_q;
        hold_pc_d  = hold_pc_q;
        if_instr_d = if_instr_q;
        if_imm_d   = if_imm_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        if (redirect_en) begin
            // Squash: bubble into IF/ID and discard any half-fetched
            // instruction. if_pc keeps its value.
            pc_d       = redirect_pc;
            if_instr_d = NOP_WORD;
            if_imm_d   = 16'h0000;
            if_valid_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                S_OP: begin
                    pc_d = pc_inc;
                    if (is_two_word) begin
                        // Park the first word until its immediate arrives.
                        hold_d     = imem_data;
                        hold_pc_d  = pc_q;
                        if_instr_d = NOP_WORD;
                        if_imm_d   = 16'h0000;
                        if_valid_d = 1'b0;
                    end else begin
                        if_instr_d = imem_data;
                        if_imm_d   = 16'h0000;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                    end
                end
                S_IMM: begin
                    // The current word is the immediate, whatever its top bits.
                    pc_d       = pc_inc;
                    if_instr_d = hold_q;
                    if_imm_d   = imem_data;
                    if_pc_d    = hold_pc_q;
                    if_valid_d = 1'b1;
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    // Datapath registers: PC, hold register and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            hold_q     <= 16'h0000;
            hold_pc_q  <= '0;
            if_instr_q <= NOP_WORD;
            if_imm_q   <= 16'h0000;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            hold_pc_q  <= hold_pc_d;
            if_instr_q <= if_instr_d;
            if_imm_q   <= if_imm_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_instr    = if_instr_q;
    assign if_imm      = if_imm_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and drives the instruction memory address.
- Assembles one- and two-word instructions into the IF/ID pipeline register that feeds the Decode stage (instruction word, immediate word, PC, valid).
- Honours the Decode stage's stall and the redirect/flush path, so it is the producer end of the fetch→decode interface.

Parameters:
- ADDR_W, 10: PC / instruction-memory word-address width.
- RESET_PC, 0: PC value loaded on reset.
- NOP_WORD, 16'h0000: instruction word presented on a bubble.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets).
- imem_addr  out  ADDR_W  instruction memory word address; always equals pc (combinational).
- imem_data  in  16  instruction memory read data for imem_addr, same cycle (asynchronous-read memory).
- stall  in  1  Decode hazard stall; freeze the fetch stage.
- redirect_en  in  1  branch/jump taken or flush; load redirect_pc and squash.
- redirect_pc  in  ADDR_W  redirect target.
- pc  out  ADDR_W  current fetch PC.
- if_instr  out  16  IF/ID instruction word (opcode = [15:10], src = [9:7], dst = [6:4]).
- if_imm  out  16  IF/ID immediate word; 0 for one-word instructions.
- if_pc  out  ADDR_W  address of if_instr's first word.
- if_valid  out  1  IF/ID register holds a real instruction.

Behaviour:
- Two-word instruction: imem_data[15:14]==2'b11. Its next sequential word is its immediate. All other encodings are one-word.
- FSM states: S_OP (fetch instruction word) and S_IMM (fetch immediate word). Reset state is S_OP.
- Reset (rst=0): pc=RESET_PC, state=S_OP, if_instr=NOP_WORD, if_imm=0, if_pc=0, if_valid=0, hold register=0. Reset overrides redirect and stall, including when it arrives mid two-word fetch.
- Edge priority: reset > redirect_en > stall > normal.
- Redirect:
  - pc ← redirect_pc, state ← S_OP.
  - IF/ID gets a bubble: if_valid=0, if_instr=NOP_WORD, if_imm=0, if_pc unchanged.
  - Any half-fetched two-word instruction is discarded.
  - Applies even when stall=1.
- Stall (no redirect): pc, state, hold register and all IF/ID outputs keep their values. imem_addr stays at pc.
- S_OP, one-word instruction:
  - if_instr ← imem_data, if_imm ← 0, if_pc ← pc, if_valid ← 1.
  - pc ← pc+1, stay in S_OP.
- S_OP, two-word instruction:
  - hold ← imem_data, hold_pc ← pc, pc ← pc+1, state ← S_IMM.
  - IF/ID gets a bubble (if_valid=0, if_instr=NOP_WORD, if_imm=0).
- S_IMM:
  - if_instr ← hold, if_imm ← imem_data, if_pc ← hold_pc, if_valid ← 1.
  - pc ← pc+1, state ← S_OP.
  - imem_data[15:14] is not decoded in this state.
- Latency: an instruction word at address A appears on IF/ID one cycle after pc=A (one-word case), or one cycle after pc=A+1 (two-word case).
- Throughput: one instruction per cycle for one-word instructions; one per two cycles for two-word instructions.
- PC arithmetic is modulo 2^ADDR_W: pc+1 from all-ones wraps to 0. A two-word instruction at the last address takes its immediate from address 0.
- Stall asserted in S_IMM: the held word is kept, and the immediate is re-read from the unchanged pc when the stall releases.
- No combinational path from stall or redirect to IF/ID outputs. imem_addr is the only combinational output.

Test Plan:
- Reset: rst=0 for 2 cycles with stall=0 → pc=0, if_valid=0, if_instr=16'h0000, imem_addr=0. Release rst=1 → pc increments 0,1,2 on successive edges.
- One-word stream: mem[0..2]=16'h1234,16'h2345,16'h0456 → IF/ID shows (1234,pc0), (2345,pc1), (0456,pc2) on consecutive cycles, if_valid=1, if_imm=0.
- Two-word instruction: mem[0]=16'hC012, mem[1]=16'hBEEF, mem[2]=16'h1111:
  - Cycle 1: if_valid=0 (bubble).
  - Cycle 2: if_instr=C012, if_imm=BEEF, if_pc=0.
  - Cycle 3: if_instr=1111, if_pc=2.
- Stall: assert stall for 3 cycles at pc=5, then in S_IMM → pc stays 5, IF/ID outputs frozen. After release, fetch resumes with no duplicate or skipped instruction, and the immediate is correct.
- Redirect: redirect_en=1, redirect_pc=10'h3F0 while stall=1 and state=S_IMM → next edge pc=3F0, if_valid=0, state S_OP. Next cycle delivers mem[3F0].
- Wrap and mid-op reset: pc=10'h3FF with mem[3FF]=16'hC001, mem[0]=16'h00AA → if_imm=00AA, if_pc=3FF, pc=1. Separately, rst=0 while in S_IMM → outputs return to reset values and the held word is never emitted.
